// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions: control-bus bit positions and MEM-stage FSM encoding.
// Execute, memory and writeback stages all import this package.
package memory_stage_pkg;

  localparam int MEM_READ_BIT   = 0;
  localparam int MEM_WRITE_BIT  = 1;
  localparam int BRANCH_BIT     = 2;
  localparam int REG_WRITE_BIT  = 0;
  localparam int MEM_TO_REG_BIT = 1;

  localparam int WAIT_CNT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A load captures the whole bundle (optionally squashing the
// writeback controls); a bubble clears only the writeback controls and holds the data.
module mem_wb_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WB_BUS_WIDTH   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_i,
  input  logic                      squash_i,
  input  logic                      bubble_i,
  input  logic [WB_BUS_WIDTH-1:0]   wb_bus_i,
  input  logic [DATA_WIDTH-1:0]     read_data_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  input  logic [REG_ADDR_WIDTH-1:0] add_reg_w_i,
  output logic [WB_BUS_WIDTH-1:0]   wb_bus_o,
  output logic [DATA_WIDTH-1:0]     read_data_o,
  output logic [DATA_WIDTH-1:0]     alu_result_o,
  output logic [REG_ADDR_WIDTH-1:0] add_reg_w_o
);

  logic [WB_BUS_WIDTH-1:0]   wb_bus_q,     wb_bus_d;
  logic [DATA_WIDTH-1:0]     read_data_q,  read_data_d;
  logic [DATA_WIDTH-1:0]     alu_result_q, alu_result_d;
  logic [REG_ADDR_WIDTH-1:0] add_reg_w_q,  add_reg_w_d;

  always_comb begin
    wb_bus_d     = wb_bus_q;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    add_reg_w_d  = add_reg_w_q;
    if (load_i) begin
      wb_bus_d     = squash_i ? '0 : wb_bus_i;
      read_data_d  = read_data_i;
      alu_result_d = alu_result_i;
      add_reg_w_d  = add_reg_w_i;
    end else if (bubble_i) begin
      // Bubble keeps the previous writeback from being applied a second time.
      wb_bus_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_bus_q     <= '0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      add_reg_w_q  <= '0;
    end else begin
      wb_bus_q     <= wb_bus_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      add_reg_w_q  <= add_reg_w_d;
    end
  end

  assign wb_bus_o     = wb_bus_q;
  assign read_data_o  = read_data_q;
  assign alu_result_o = alu_result_q;
  assign add_reg_w_o  = add_reg_w_q;

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: decodes memory controls, runs word accesses over a req/ack port with a
// timeout watchdog, stalls upstream while waiting, and resolves branches combinationally.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MEM_BUS_WIDTH-1:0]  memory_bus_in,
  input  logic [WB_BUS_WIDTH-1:0]   wb_bus_in,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     reg_rt_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] add_reg_w_in,
  input  logic                      alu_zero_flag_in,
  input  logic [DATA_WIDTH-1:0]     branch_target_in,
  output logic                      pc_src_out,
  output logic [DATA_WIDTH-1:0]     branch_target_out,
  output logic                      stall_out,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  input  logic                      dmem_ack,
  output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
  output logic [DATA_WIDTH-1:0]     read_data_out,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [REG_ADDR_WIDTH-1:0] add_reg_w_out,
  output logic                      misaligned_out,
  output logic                      timeout_out
);

  localparam logic [WAIT_CNT_W:0] TO_LIM = 9'(TIMEOUT_CYCLES);

  mem_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    misaligned_q, misaligned_d;
  logic                    timeout_q, timeout_d;

  logic mem_read, mem_write, access, illegal, start, timed_out;
  logic mwb_load, mwb_squash, rdata_sel;

  assign mem_read  = memory_bus_in[MEM_READ_BIT];
  assign mem_write = memory_bus_in[MEM_WRITE_BIT];
  assign access    = mem_read | mem_write;
  assign illegal   = access & ((alu_result_in[1:0] != 2'b00) | (mem_read & mem_write));
  assign start     = (state_q == ST_IDLE) & access & ~illegal;

  // An ack in the same cycle as the limit wins over the watchdog.
  assign timed_out = (state_q == ST_WAIT) & ~dmem_ack & (({1'b0, cnt_q} + 9'd1) >= TO_LIM);

  assign pc_src_out        = memory_bus_in[BRANCH_BIT] & alu_zero_flag_in;
  assign branch_target_out = branch_target_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_WAIT;
      ST_WAIT: if (dmem_ack || timed_out) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dmem_req   = 1'b0;
    stall_out  = 1'b0;
    mwb_load   = 1'b0;
    mwb_squash = 1'b0;
    rdata_sel  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_out  = start;
        mwb_load   = ~start;
        mwb_squash = illegal;
      end
      ST_WAIT: begin
        dmem_req   = 1'b1;
        stall_out  = ~dmem_ack & ~timed_out;
        mwb_load   = dmem_ack | timed_out;
        mwb_squash = timed_out;
        rdata_sel  = dmem_ack & ~we_q;
      end
      default: ;
    endcase
  end

  // Access latch, saturating wait counter and registered error pulses.
  always_comb begin
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (start) begin
        we_d    = mem_write;
        addr_d  = alu_result_in;
        wdata_d = reg_rt_data_in;
      end
    end else if (!dmem_ack && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    misaligned_d = (state_q == ST_IDLE) & illegal;
    timeout_d    = timed_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign misaligned_out = misaligned_q;
  assign timeout_out    = timeout_q;

  mem_wb_reg #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .WB_BUS_WIDTH  (WB_BUS_WIDTH)
  ) u_mem_wb_reg (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (mwb_load),
    .squash_i    (mwb_squash),
    .bubble_i    (stall_out),
    .wb_bus_i    (wb_bus_in),
    .read_data_i (rdata_sel ? dmem_rdata : '0),
    .alu_result_i(alu_result_in),
    .add_reg_w_i (add_reg_w_in),
    .wb_bus_o    (wb_bus_out),
    .read_data_o (read_data_out),
    .alu_result_o(alu_result_out),
    .add_reg_w_o (add_reg_w_out)
  );

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed vector table, reset/late-ack sequences and random
// instructions checked against a transaction-level model of the stage.
module tb_memory_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  memory_bus_in;
  logic [1:0]  wb_bus_in;
  logic [31:0] alu_result_in, reg_rt_data_in, branch_target_in;
  logic [4:0]  add_reg_w_in;
  logic        alu_zero_flag_in;
  logic        pc_src_out, stall_out, dmem_req, dmem_we, dmem_ack;
  logic [31:0] branch_target_out, dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  wb_bus_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  add_reg_w_out;
  logic        misaligned_out, timeout_out;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .memory_bus_in(memory_bus_in), .wb_bus_in(wb_bus_in),
    .alu_result_in(alu_result_in), .reg_rt_data_in(reg_rt_data_in),
    .add_reg_w_in(add_reg_w_in), .alu_zero_flag_in(alu_zero_flag_in),
    .branch_target_in(branch_target_in), .pc_src_out(pc_src_out),
    .branch_target_out(branch_target_out), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_bus_out(wb_bus_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .add_reg_w_out(add_reg_w_out),
    .misaligned_out(misaligned_out), .timeout_out(timeout_out)
  );

  typedef struct {
    logic [2:0]  mb;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        zero;
    logic [31:0] tgt;
    int          delay;   // unacked WAIT cycles before the ack
    logic [31:0] rdata;
    int          e_stall;
    int          e_noack;
    logic [1:0]  e_wb;
    logic [31:0] e_read;
    logic        e_mis;
    logic        e_to;
    logic        e_pc;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] mb, input logic [1:0] wb, input logic [31:0] alu,
                              input logic [31:0] rt, input logic [4:0] rd, input logic zero,
                              input logic [31:0] tgt, input int delay, input logic [31:0] rdata,
                              input int e_stall, input int e_noack, input logic [1:0] e_wb,
                              input logic [31:0] e_read, input logic e_mis, input logic e_to,
                              input logic e_pc);
    vec_t v;
    v.mb = mb; v.wb = wb; v.alu = alu; v.rt = rt; v.rd = rd; v.zero = zero; v.tgt = tgt;
    v.delay = delay; v.rdata = rdata; v.e_stall = e_stall; v.e_noack = e_noack;
    v.e_wb = e_wb; v.e_read = e_read; v.e_mis = e_mis; v.e_to = e_to; v.e_pc = e_pc;
    return v;
  endfunction

  // Transaction-level reference: outcome of one instruction from the stage's rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit rd = v.mb[0], wr = v.mb[1];
    bit acc = rd | wr;
    bit ill = acc && ((v.alu[1:0] != 2'b00) || (rd && wr));
    r.e_pc = v.mb[2] & v.zero;
    r.e_mis = 0; r.e_to = 0; r.e_read = 0; r.e_stall = 0; r.e_noack = 0; r.e_wb = v.wb;
    if (acc && ill) begin
      r.e_mis = 1; r.e_wb = 2'b00;
    end else if (acc && v.delay < T) begin
      r.e_stall = v.delay + 1; r.e_noack = v.delay;
      r.e_read = rd ? v.rdata : 32'h0;
    end else if (acc) begin
      r.e_stall = T; r.e_noack = T; r.e_wb = 2'b00; r.e_to = 1;
    end
    return r;
  endfunction

  // Entered and left 1 time unit after a rising edge.
  task automatic run_vec(input string tag, input vec_t v);
    int stalls = 0, noack = 0, waits = 0;
    bit bubble_ok = 1, port_ok = 1, done = 0;
    memory_bus_in = v.mb; wb_bus_in = v.wb; alu_result_in = v.alu; reg_rt_data_in = v.rt;
    add_reg_w_in = v.rd; alu_zero_flag_in = v.zero; branch_target_in = v.tgt;
    dmem_ack = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (dmem_req) begin
        dmem_ack = (waits == v.delay);
        dmem_rdata = dmem_ack ? v.rdata : $urandom();
        if (dmem_we !== v.mb[1] || dmem_addr !== v.alu || dmem_wdata !== v.rt) port_ok = 0;
        if (!dmem_ack) noack++;
        waits++;
      end else begin
        dmem_ack = 1'b0;
        dmem_rdata = $urandom();
      end
      #3;
      if (cyc == 0) begin
        chk({tag, " pc_src"}, 32'(pc_src_out), 32'(v.e_pc));
        chk({tag, " branch_target"}, branch_target_out, v.tgt);
      end
      if (stall_out) begin
        stalls++;
        if (cyc > 0 && wb_bus_out !== 2'b00) bubble_ok = 0;
      end else done = 1;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(v.e_stall));
    chk({tag, " req cycles without ack"}, 32'(noack), 32'(v.e_noack));
    chk({tag, " bubble during stall"}, 32'(bubble_ok), 32'd1);
    chk({tag, " dmem port fields"}, 32'(port_ok), 32'd1);
    chk({tag, " wb_bus_out"}, 32'(wb_bus_out), 32'(v.e_wb));
    chk({tag, " read_data_out"}, read_data_out, v.e_read);
    chk({tag, " alu_result_out"}, alu_result_out, v.alu);
    chk({tag, " add_reg_w_out"}, 32'(add_reg_w_out), 32'(v.rd));
    chk({tag, " misaligned_out"}, 32'(misaligned_out), 32'(v.e_mis));
    chk({tag, " timeout_out"}, 32'(timeout_out), 32'(v.e_to));
    // Follow-up ALU op; after a timeout the memory sends a stray late ack.
    memory_bus_in = 3'b000; wb_bus_in = 2'b01; alu_result_in = ~v.alu; add_reg_w_in = v.rd + 5'd1;
    dmem_ack = v.e_to; dmem_rdata = 32'hBAD0_BAD0;
    #3;
    chk({tag, " follow-up req"}, 32'(dmem_req), 32'd0);
    chk({tag, " follow-up stall"}, 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk({tag, " follow-up wb"}, 32'(wb_bus_out), 32'd1);
    chk({tag, " follow-up read_data"}, read_data_out, 32'h0);
    chk({tag, " error pulses end"}, 32'({misaligned_out, timeout_out}), 32'd0);
  endtask

  vec_t tbl[9];

  initial begin
    vec_t v;
    tbl[0] = mk(3'b000, 2'b01, 32'h1234, 32'h0, 5'd3, 1'b0, 32'h0, 0, 32'h0,
                0, 0, 2'b01, 32'h0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(3'b001, 2'b11, 32'h100, 32'h55, 5'd8, 1'b0, 32'h0, 3, 32'hDEADBEEF,
                4, 3, 2'b11, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    tbl[2] = mk(3'b010, 2'b00, 32'h200, 32'hCAFE, 5'd0, 1'b0, 32'h0, 0, 32'h7777_7777,
                1, 0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    tbl[3] = mk(3'b001, 2'b11, 32'h102, 32'h0, 5'd9, 1'b0, 32'h0, 0, 32'h1,
                0, 0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
    tbl[4] = mk(3'b001, 2'b11, 32'h300, 32'h0, 5'd10, 1'b0, 32'h0, 99, 32'h2,
                4, 4, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
    tbl[5] = mk(3'b011, 2'b11, 32'h400, 32'h0, 5'd11, 1'b0, 32'h0, 0, 32'h0,
                0, 0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
    tbl[6] = mk(3'b100, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 32'h40, 0, 32'h0,
                0, 0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
    tbl[7] = mk(3'b100, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h40, 0, 32'h0,
                0, 0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    tbl[8] = mk(3'b101, 2'b11, 32'h80, 32'h0, 5'd12, 1'b1, 32'h88, 1, 32'h12345678,
                2, 1, 2'b11, 32'h12345678, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0;
    memory_bus_in = '0; wb_bus_in = '0; alu_result_in = '0; reg_rt_data_in = '0;
    add_reg_w_in = '0; alu_zero_flag_in = 1'b0; branch_target_in = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset wb_bus_out", 32'(wb_bus_out), 32'd0);
    chk("reset read_data_out", read_data_out, 32'h0);
    chk("reset alu_result_out", alu_result_out, 32'h0);
    chk("reset add_reg_w_out", 32'(add_reg_w_out), 32'd0);
    chk("reset req/stall/errors", 32'({dmem_req, stall_out, misaligned_out, timeout_out}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Reset asserted while an access is outstanding.
    memory_bus_in = 3'b001; wb_bus_in = 2'b11; alu_result_in = 32'h500; add_reg_w_in = 5'd4;
    @(posedge clk); #1;
    chk("midwait req before reset", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("midwait req dropped by reset", 32'(dmem_req), 32'd0);
    memory_bus_in = 3'b000; wb_bus_in = 2'b00;
    @(posedge clk); #1;
    chk("midwait reset wb_bus_out", 32'(wb_bus_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after reset req idle", 32'(dmem_req), 32'd0);

    for (int i = 0; i < 40; i++) begin
      v = mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFFC,
             $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom(),
             $urandom_range(0, 5), $urandom(), 0, 0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 4) == 0) v.alu[1:0] = 2'($urandom_range(1, 3));
      run_vec($sformatf("rnd%0d", i), model(v));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
